// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// opcode legality, FSM states and the optional result reference model.
// Optional feature macro: ALU_SEQ_SELFCHECK_EN
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_NEG = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;
  localparam logic [3:0] OP_OR  = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
  localparam logic [3:0] OP_ROL = 4'b1101;
  localparam logic [3:0] OP_SHR = 4'b1110;
  localparam logic [3:0] OP_SHL = 4'b1111;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_NEG, OP_AND, OP_XOR, OP_OR,
      OP_NOT, OP_ROR, OP_ROL, OP_SHR, OP_SHL: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

`ifdef ALU_SEQ_SELFCHECK_EN
  // Expected ALU output; rotates and shifts are by one bit, all mod 256.
  function automatic logic [7:0] exp_result(input logic [3:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NEG:  return ~a + 8'd1;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_NOT:  return ~a;
      OP_ROR:  return {a[0], a[7:1]};
      OP_ROL:  return {a[6:0], a[7]};
      OP_SHR:  return {1'b0, a[7:1]};
      OP_SHL:  return {a[6:0], 1'b0};
      default: return 8'h00;
    endcase
  endfunction
`endif

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate count.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; empty pointers make stale contents unobservable.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side initiator for the behavioural ALU: buffers commands, issues
// them one at a time, waits ALU_LAT edges, and returns tagged results.
// Optional feature macro: ALU_SEQ_SELFCHECK_EN (reference-model mismatch check).
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_s,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             busy
`ifdef ALU_SEQ_SELFCHECK_EN
  ,
  output logic             rsp_mismatch,
  output logic [7:0]       mismatch_cnt
`endif
);

  localparam int CMD_W = 20 + TAG_W;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]         alu_s_q, alu_s_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_neg_q, rsp_neg_d;
`ifdef ALU_SEQ_SELFCHECK_EN
  logic               mism_q, mism_d;
  logic [7:0]         mcnt_q, mcnt_d;
`endif

  logic               fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0]   head;
  logic [3:0]         head_op;
  logic [7:0]         head_a, head_b;
  logic [TAG_W-1:0]   head_tag;

  alu_seq_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .pop_i   (fifo_pop),
    .wdata_i ({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_op, head_a, head_b, head_tag} = head;

  // Next-state and issue/capture logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
    rsp_zero_d = rsp_zero_q;
    rsp_neg_d  = rsp_neg_q;
    fifo_pop   = 1'b0;
`ifdef ALU_SEQ_SELFCHECK_EN
    mism_d     = mism_q;
    mcnt_d     = mcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          rsp_tag_d = head_tag;
          if (is_legal_op(head_op)) begin
            alu_a_d = head_a;
            alu_b_d = head_b;
            alu_s_d = head_op;
            cnt_d   = 4'(ALU_LAT);
            state_d = WAIT;
          end else begin
            // Illegal opcode is reported without touching the ALU.
            rsp_err_d  = 1'b1;
            rsp_data_d = 8'h00;
            rsp_zero_d = 1'b1;
            rsp_neg_d  = 1'b0;
`ifdef ALU_SEQ_SELFCHECK_EN
            mism_d     = 1'b0;
`endif
            state_d    = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
          rsp_zero_d = (alu_result == 8'h00);
          rsp_neg_d  = alu_result[7];
`ifdef ALU_SEQ_SELFCHECK_EN
          mism_d = (alu_result != exp_result(alu_s_q, alu_a_q, alu_b_q));
          if (mism_d && mcnt_q != 8'hFF) mcnt_d = mcnt_q + 8'd1;
`endif
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
`ifdef ALU_SEQ_SELFCHECK_EN
      mism_q     <= 1'b0;
      mcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_neg_q  <= rsp_neg_d;
`ifdef ALU_SEQ_SELFCHECK_EN
      mism_q     <= mism_d;
      mcnt_q     <= mcnt_d;
`endif
    end
  end

  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign rsp_valid = (state_q == RESP);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_neg   = rsp_neg_q;
`ifdef ALU_SEQ_SELFCHECK_EN
  assign rsp_mismatch = mism_q;
  assign mismatch_cnt = mcnt_q;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side initiator for the 8-bit behavioural ALU (alu_behavioral). It accepts operation commands (opcode, A, B, tag) on a valid/ready stream and buffers them in a small FIFO. It drives the ALU's A/B/s inputs one command at a time, waits the ALU latency, and captures alu_out. The result is returned with status flags on a valid/ready response stream. It sits between a test or microcode controller and the ALU datapath.

Parameters:
DEPTH, 4, command FIFO entries; power of two, 2..16
ALU_LAT, 1, clock edges from operands being driven to alu_out being valid; range 1..15
TAG_W, 4, width of the opaque command tag returned with the response

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO not full
cmd_op  in  4  ALU opcode (s encoding)
cmd_a  in  8  operand A
cmd_b  in  8  operand B
cmd_tag  in  TAG_W  opaque tag
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_s  out  4  to ALU s
alu_result  in  8  from ALU alu_out
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  captured result
rsp_tag  out  TAG_W  tag of the completed command
rsp_err  out  1  illegal opcode; command not issued
rsp_zero  out  1  rsp_data == 0
rsp_neg  out  1  rsp_data[7]
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async assert) clears everything:
  - FIFO empties.
  - FSM goes to IDLE.
  - alu_a, alu_b, alu_s and all rsp_* outputs are 0.
  - busy is 0 and cmd_ready is 1.
- Reset asserted mid-WAIT or mid-RESP drops the in-flight command with no response.
- Command push: cmd_valid && cmd_ready at an edge. cmd_ready = !full, with no full-bypass, so a push and a pop in the same cycle while full is refused. Push and pop together when not full are both honoured.
- Legal opcodes (from the package): ADD 0000, SUB 0001, NEG 0011, AND 1000, XOR 1001, OR 1010, NOT 1011, ROR 1100, ROL 1101, SHR 1110, SHL 1111. All others are illegal.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head.
    - Legal opcode: register alu_a/alu_b/alu_s, load the counter with ALU_LAT, go to WAIT.
    - Illegal opcode: leave alu_* unchanged, set rsp_err=1 and rsp_data=0, go to RESP.
  - WAIT: decrement the counter each edge. On the edge where the counter reaches 0, capture alu_result into rsp_data, set rsp_err=0 and the flags, go to RESP.
  - RESP: rsp_valid=1; rsp_* are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid. rsp_ready is ignored in other states.
- alu_a/alu_b/alu_s hold their last issued values between commands.
- Latency with ALU_LAT=1 and an empty FIFO:
  - Command accepted at edge 0.
  - Operands driven after edge 1.
  - Result captured at edge 2; rsp_valid high after edge 2.
  - Throughput is at most one command per (ALU_LAT + 2) cycles.
- Capacity: one command in the FSM plus DEPTH in the FIFO, so DEPTH+1 commands are accepted before cmd_ready drops while rsp_ready is held low.
- Responses return in command order.
- Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.

Optional Feature:
ALU_SEQ_SELFCHECK_EN
- Defined:
  - An internal reference model computes the expected result from the issued operands and opcode. ROR/ROL are 1-bit rotates, SHR/SHL are logical 1-bit shifts, NEG = ~A+1, NOT = ~A, all mod 256.
  - Adds output rsp_mismatch (1 bit, valid with rsp_valid).
  - Adds output mismatch_cnt (8 bits, saturating at 255, cleared by rst).
  - The count increments once per mismatching response, at the capture edge.
- Undefined: neither port exists and there is no model logic.

Decomposition:
- Package alu_seq_pkg:
  - 4-bit opcode localparams (OP_ADD … OP_SHL).
  - is_legal_op function.
  - FSM state enum {IDLE, WAIT, RESP}.
  - expected-result function used under ALU_SEQ_SELFCHECK_EN.
- Sub-module alu_seq_fifo: parameterised DEPTH synchronous FIFO with push/pop/full/empty, 8+8+4+TAG_W bits wide.

Test Plan:
- ADD: op=0000, A=10, B=5, tag=3 → rsp_data=15, rsp_tag=3, err=0, zero=0; rsp_valid rises 2 edges after acceptance (ALU_LAT=1).
- SUB to zero: op=0001, A=8, B=8 → rsp_data=0, zero=1.
- SUB negative: op=0001, A=5, B=8 → rsp_data=0xFD, neg=1.
- Illegal opcode: op=0010, A=7 → rsp_err=1, rsp_data=0, alu_s keeps its previous value; the next legal AND 0xD3&0x6C still returns 0x40.
- Backpressure: hold rsp_ready=0 and offer 6 commands with DEPTH=4 → exactly 5 accepted, cmd_ready=0. Release rsp_ready → 5 responses in tag order, then cmd_ready=1.
- Reset mid-WAIT with ALU_LAT=3: assert rst during WAIT → all outputs 0 immediately, no response after release, busy=0.
- Self-check (ALU_SEQ_SELFCHECK_EN): stub ALU returns A+B+1 for ROL A=0xB3 → rsp_mismatch=1, mismatch_cnt=1. Correct ROL returns 0x67, rsp_mismatch=0.
